// File: rtl/mem_access_ctrl_if.sv
// Bundle between the EX/MEM pipeline, the load/store sequencer and the data SRAM bus.
// master = sequencer side, slave = pipeline + SRAM side.
`timescale 1ns/1ps
interface mem_access_ctrl_if;
  // Handshakes: the pipeline holds req_valid and all req_* fields stable while stallreq=1.
  // Bus side: data_req stays high with constant fields until a cycle with data_addr_ok=1.
  // data_data_ok may arrive in that same cycle or any later one.
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic        bus_err;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    output stallreq, resp_valid, resp_rdata, addr_err, bus_err,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    input  stallreq, resp_valid, resp_rdata, addr_err, bus_err,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one access at a time over an addr_ok/data_ok SRAM bus,
// stalling the pipeline until the access completes, times out or is rejected.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.master mif,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] lane_w;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] load_val;
  logic [31:0] capture_val;

  // Size 3 is treated as a word everywhere.
  always_comb begin
    misaligned = 1'b0;
    st_strb    = 4'hF;
    st_data    = mif.req_wdata;
    case (mif.req_size)
      2'd0: begin
        st_strb = 4'b0001 << mif.req_addr[1:0];
        st_data = {4{mif.req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = mif.req_addr[0];
        st_strb    = 4'b0011 << {mif.req_addr[1], 1'b0};
        st_data    = {2{mif.req_wdata[15:0]}};
      end
      default: misaligned = (mif.req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    lane_w   = mif.data_rdata >> {addr_q[1:0], 3'b000};
    ld_b     = lane_w[7:0];
    ld_h     = lane_w[15:0];
    load_val = mif.data_rdata;
    case (size_q)
      2'd0:    load_val = uns_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'd1:    load_val = uns_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: load_val = mif.data_rdata;
    endcase
    capture_val = we_q ? 32'h0 : load_val;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wstrb_d        = wstrb_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    mif.stallreq   = 1'b0;
    mif.resp_valid = 1'b0;
    mif.addr_err   = 1'b0;
    mif.bus_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst so a request still held during reset produces no output.
        if (rst && mif.req_valid) begin
          if (misaligned) begin
            mif.addr_err = 1'b1;
          end else begin
            mif.stallreq = 1'b1;
            we_d         = mif.req_we;
            size_d       = mif.req_size;
            uns_d        = mif.req_unsigned;
            addr_d       = mif.req_addr;
            wstrb_d      = mif.req_we ? st_strb : 4'h0;
            wdata_d      = mif.req_we ? st_data : 32'h0;
            cnt_d        = 8'h0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        mif.stallreq = 1'b1;
        cnt_d        = cnt_q + 8'h1;
        if (mif.data_addr_ok && mif.data_data_ok) begin
          rdata_d = capture_val;
          state_d = S_DONE;
        end else if (cnt_q == LIMIT) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mif.data_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mif.stallreq = 1'b1;
        cnt_d        = cnt_q + 8'h1;
        if (mif.data_data_ok) begin
          rdata_d = capture_val;
          state_d = S_DONE;
        end else if (cnt_q == LIMIT) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        // DONE never accepts: the still-held req_valid belongs to this access.
        mif.resp_valid = 1'b1;
        mif.bus_err    = err_q;
        err_d          = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mif.data_req   = (state_q == S_REQ);
  assign mif.data_wr    = we_q;
  assign mif.data_size  = size_q;
  assign mif.data_addr  = addr_q;
  assign mif.data_wstrb = wstrb_q;
  assign mif.data_wdata = wdata_q;
  assign mif.resp_rdata = rdata_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a long-timeout instance for normal traffic and a
// MAX_WAIT=4 instance for timeout behaviour, both checked against a spec-level model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // sel=0 drives/observes the main instance, sel=1 the short-timeout instance.
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, data_rdata = 32'h0;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [1:0]  dbg_m, dbg_t;
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  mem_access_ctrl_if mif ();
  mem_access_ctrl_if mif_t ();

  mem_access_ctrl #(.MAX_WAIT(255)) dut (
    .clk(clk), .rst(rst), .mif(mif), .dbg_state_o(dbg_m));
  mem_access_ctrl #(.MAX_WAIT(4)) dut_t (
    .clk(clk), .rst(rst), .mif(mif_t), .dbg_state_o(dbg_t));

  assign mif.req_valid      = req_valid & ~sel;
  assign mif_t.req_valid    = req_valid & sel;
  assign mif.data_addr_ok   = addr_ok & ~sel;
  assign mif_t.data_addr_ok = addr_ok & sel;
  assign mif.data_data_ok   = data_ok & ~sel;
  assign mif_t.data_data_ok = data_ok & sel;
  assign mif.req_we = req_we;           assign mif_t.req_we = req_we;
  assign mif.req_size = req_size;       assign mif_t.req_size = req_size;
  assign mif.req_unsigned = req_unsigned; assign mif_t.req_unsigned = req_unsigned;
  assign mif.req_addr = req_addr;       assign mif_t.req_addr = req_addr;
  assign mif.req_wdata = req_wdata;     assign mif_t.req_wdata = req_wdata;
  assign mif.data_rdata = data_rdata;   assign mif_t.data_rdata = data_rdata;

  wire        o_stall = sel ? mif_t.stallreq   : mif.stallreq;
  wire        o_resp  = sel ? mif_t.resp_valid : mif.resp_valid;
  wire [31:0] o_rdata = sel ? mif_t.resp_rdata : mif.resp_rdata;
  wire        o_aerr  = sel ? mif_t.addr_err   : mif.addr_err;
  wire        o_berr  = sel ? mif_t.bus_err    : mif.bus_err;
  wire        o_req   = sel ? mif_t.data_req   : mif.data_req;
  wire        o_wr    = sel ? mif_t.data_wr    : mif.data_wr;
  wire [1:0]  o_size  = sel ? mif_t.data_size  : mif.data_size;
  wire [31:0] o_addr  = sel ? mif_t.data_addr  : mif.data_addr;
  wire [3:0]  o_wstrb = sel ? mif_t.data_wstrb : mif.data_wstrb;
  wire [31:0] o_wdata = sel ? mif_t.data_wdata : mif.data_wdata;

  // One access: model expectations, then act as the SRAM cycle by cycle.
  // a_dly = REQ cycles before addr_ok, d_dly = further cycles until data_ok (0 = same cycle).
  task automatic do_access(input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input int a_dly, input int d_dly,
                           input int mw, input string tag);
    int eff, n, last;
    bit mis, tmo;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd, lane, v, exp_rd, got_exp;
    eff = (size == 2'd3) ? 2 : int'(size);
    mis = (addr % (32'd1 << eff)) != 0;
    exp_strb = 4'((eff == 0) ? (1 << (addr % 4)) : (eff == 1) ? (3 << (addr % 4)) : 15);
    if (!we) exp_strb = 4'h0;
    exp_wd = (eff == 0) ? (wdata & 32'hFF) * 32'h01010101 :
             (eff == 1) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
    lane = rword >> (8 * (addr % 4));
    if (eff == 0) begin
      v = lane & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (eff == 1) begin
      v = lane & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = rword;
    end
    n    = a_dly + 1 + d_dly;
    tmo  = n > mw;
    last = tmo ? mw : n;
    exp_rd = (tmo || we) ? 32'h0 : v;

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    if (mis) begin
      n_cmp++;
      if ({o_aerr, o_stall, o_req} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s misaligned accept: aerr/stall/req=%b want 100", tag, {o_aerr, o_stall, o_req});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({o_aerr, o_stall, o_req, o_resp} !== 4'b0000 || o_rdata !== last_rd[sel]) begin
        n_fail++;
        $display("FAIL %s misaligned after: aerr/stall/req/resp=%b rdata=%h want 0000 %h",
                 tag, {o_aerr, o_stall, o_req, o_resp}, o_rdata, last_rd[sel]);
      end
      return;
    end
    exp_q.push_back(exp_rd);
    n_cmp++;
    if ({o_stall, o_req, o_aerr, o_resp} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s accept: stall/req/aerr/resp=%b want 1000", tag, {o_stall, o_req, o_aerr, o_resp});
    end
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk); #1;
      addr_ok    = (c == a_dly + 1) && (c <= last);
      data_ok    = (c == n) && (c <= last);
      data_rdata = data_ok ? rword : $urandom;
      @(negedge clk);
      if (c <= last) begin
        n_cmp++;
        if ({o_stall, o_resp, o_req} !== {1'b1, 1'b0, (c <= a_dly + 1) ? 1'b1 : 1'b0}) begin
          n_fail++;
          $display("FAIL %s cycle %0d: stall/resp/req=%b want 1,0,%0d", tag, c,
                   {o_stall, o_resp, o_req}, (c <= a_dly + 1));
        end
        if (c <= a_dly + 1) begin
          n_cmp++;
          if ({o_wr, o_size, o_addr, o_wstrb} !== {we, size, addr, exp_strb}) begin
            n_fail++;
            $display("FAIL %s bus fields c%0d: wr=%b size=%0d addr=%h strb=%b want %b %0d %h %b",
                     tag, c, o_wr, o_size, o_addr, o_wstrb, we, size, addr, exp_strb);
          end
          if (we) begin
            n_cmp++;
            if (o_wdata !== exp_wd) begin
              n_fail++;
              $display("FAIL %s wdata c%0d: got %h want %h", tag, c, o_wdata, exp_wd);
            end
          end
        end
      end else begin
        got_exp = exp_q.pop_front();
        n_cmp++;
        if ({o_resp, o_stall, o_req, o_berr} !== {1'b1, 1'b0, 1'b0, tmo} || o_rdata !== got_exp) begin
          n_fail++;
          $display("FAIL %s done: resp/stall/req/berr=%b rdata=%h want 1,0,0,%0d %h",
                   tag, {o_resp, o_stall, o_req, o_berr}, o_rdata, tmo, got_exp);
        end
        last_rd[sel] = got_exp;
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({o_stall, o_resp, o_aerr, o_berr, o_req} !== 5'b0 || o_rdata !== last_rd[sel]) begin
        n_fail++;
        $display("FAIL idle: stall/resp/aerr/berr/req=%b rdata=%h want 00000 %h",
                 {o_stall, o_resp, o_aerr, o_berr, o_req}, o_rdata, last_rd[sel]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      n_cmp++;
      if ({o_stall, o_resp, o_aerr, o_berr, o_req, o_wr, o_size, o_addr, o_wstrb, o_wdata, o_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset outputs inst%0d: req=%b addr=%h rdata=%h want all 0", s, o_req, o_addr, o_rdata);
      end
    end
    sel = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_spec_vectors();
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h12345678, 0, 0, 255, "lw_0x100");
    idle(1);
    do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 255, "lb_0x103");
    do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0, 255, "lbu_0x103");
    do_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 32'h0, 3, 2, 255, "sh_0x102");
    do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 255, "lw_0x101_mis");
    idle(1);
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(1, 3));
      a  = $urandom;
      a[0] = (sz == 2'd1) ? 1'b1 : a[0];
      if (sz != 2'd1 && a[1:0] == 2'b00) a[1:0] = 2'($urandom_range(1, 3));
      do_access(1'($urandom_range(0, 1)), sz, 1'b0, a, $urandom, $urandom, 0, 0, 255, "rand_mis");
    end
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'b00;
      end
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 255, "rand");
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_access(1'b0, 2'd2, 1'b0, 32'h300 + 32'(4 * i), 32'h0, $urandom, 0, 0, 255, "b2b");
    idle(1);
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    idle(1);
    do_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 3, 4, "tmo_dataok_wins");
    do_access(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, $urandom, 1, 5, 4, "tmo_in_wait");
    do_access(1'b1, 2'd0, 1'b0, 32'h45, 32'hA5, 32'h0, 9, 0, 4, "tmo_in_req");
    @(posedge clk); #1;
    req_valid = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; data_rdata = 32'h55AA55AA;
    @(negedge clk);
    n_cmp++;
    if ({o_resp, o_stall, o_req, o_berr} !== 4'b0000 || o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL late data_ok: resp/stall/req/berr=%b rdata=%h want 0000 0",
               {o_resp, o_stall, o_req, o_berr}, o_rdata);
    end
    idle(2);
    sel = 1'b0;
  endtask

  task automatic test_rst_mid_wait();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200; addr_ok = 1'b0; data_ok = 1'b0;
    @(posedge clk); #1;
    addr_ok = 1'b1;
    @(posedge clk); #1;
    addr_ok = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_stall, o_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL pre-reset wait: stall/req=%b want 10", {o_stall, o_req});
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_stall, o_resp, o_aerr, o_berr, o_req, o_wr, o_size, o_addr, o_wstrb, o_wdata, o_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset mid-wait: stall=%b req=%b addr=%h rdata=%h want all 0", o_stall, o_req, o_addr, o_rdata);
    end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if ({o_resp, o_stall, o_req} !== 3'b000 || o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL data_ok after reset: resp/stall/req=%b rdata=%h want 000 0", {o_resp, o_stall, o_req}, o_rdata);
    end
    idle(1);
    do_access(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'h0BADF00D, 1, 1, 255, "lw_after_reset");
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_timeout();
    test_rst_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
